// File: rtl/dram_ctrl_if.sv
// Host command/response and DRAM command/data signals for dram_ctrl.
// slave = controller view, master = host + DRAM-device view.
interface dram_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_done;
  logic       err;
  logic       r;
  logic       w;
  logic       mrw;
  logic       mrr;
  logic [7:0] addr;
  logic [7:0] mr_in;
  logic [7:0] dq_in_delay;
  logic       driv_valid;
  logic [7:0] dq_out;
  logic       dq_oe;
  logic [7:0] mr_out;

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, dq_out, dq_oe, mr_out,
    output cmd_ready, rsp_valid, rsp_data, init_done, err,
           r, w, mrw, mrr, addr, mr_in, dq_in_delay, driv_valid
  );

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, dq_out, dq_oe, mr_out,
    input  cmd_ready, rsp_valid, rsp_data, init_done, err,
           r, w, mrw, mrr, addr, mr_in, dq_in_delay, driv_valid
  );
endinterface

// File: rtl/dram_ctrl.sv
// DRAM command controller: MR init, read/write issue, WL-timed write data.
// Define DRAM_CTRL_MR_CHECK_EN to read back and verify MR0/MR1 after init.
module dram_ctrl #(
  parameter int unsigned RL   = 4,
  parameter int unsigned WL   = 3,
  parameter int unsigned OUTS = 8
) (
  input logic        clk,
  input logic        rst,
  dram_ctrl_if.slave bus
);

  localparam int unsigned CW  = $clog2(OUTS + 1);
  localparam int unsigned PW  = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam logic [7:0]  RL8 = 8'(RL);
  localparam logic [7:0]  WL8 = 8'(WL);

  typedef enum logic [3:0] {
    ST_RESET, ST_MRW0, ST_MRW1, ST_MRR0, ST_CHK0,
    ST_MRR1, ST_CHK1, ST_READY, ST_ERROR
  } state_t;

  state_t         state;
  logic [7:0]     cyc;
  logic [CW-1:0]  rd_cnt, rd_cnt_next;
  logic [CW-1:0]  wr_cnt, wr_cnt_next;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [7:0]     fifo_data  [OUTS];
  logic [7:0]     fifo_stamp [OUTS];
  logic [7:0]     head_age;
  logic           accept, issue_rd, issue_wr, head_due, rsp_ok, can_accept;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Stamps hold the cycle the W strobe is visible; the head leaves the
  // FIFO on the edge that makes DRIV_VALID visible exactly WL cycles later.
  always_comb begin
    accept   = bus.cmd_valid & bus.cmd_ready;
    issue_rd = accept & ~bus.cmd_we;
    issue_wr = accept & bus.cmd_we;
    head_age = cyc - fifo_stamp[rd_ptr] + 8'd1;
    head_due = (wr_cnt != '0) && (head_age == WL8);
    rsp_ok   = bus.dq_oe && (rd_cnt != '0);

    rd_cnt_next = rd_cnt;
    if (issue_rd && !rsp_ok)      rd_cnt_next = rd_cnt + CW'(1);
    else if (!issue_rd && rsp_ok) rd_cnt_next = rd_cnt - CW'(1);

    wr_cnt_next = wr_cnt;
    if (issue_wr && !head_due)      wr_cnt_next = wr_cnt + CW'(1);
    else if (!issue_wr && head_due) wr_cnt_next = wr_cnt - CW'(1);

    can_accept = (rd_cnt_next < CW'(OUTS)) && (wr_cnt_next < CW'(OUTS));
  end

  always_ff @(posedge clk) begin
    if (issue_wr) begin
      fifo_data[wr_ptr]  <= bus.cmd_wdata;
      fifo_stamp[wr_ptr] <= cyc + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RESET;
      cyc             <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.init_done   <= 1'b0;
      bus.err         <= 1'b0;
      bus.r           <= 1'b0;
      bus.w           <= 1'b0;
      bus.mrw         <= 1'b0;
      bus.mrr         <= 1'b0;
      bus.addr        <= '0;
      bus.mr_in       <= '0;
      bus.driv_valid  <= 1'b0;
      bus.dq_in_delay <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
    end else begin
      cyc           <= cyc + 8'd1;
      rd_cnt        <= rd_cnt_next;
      wr_cnt        <= wr_cnt_next;
      bus.r         <= 1'b0;
      bus.w         <= 1'b0;
      bus.mrw       <= 1'b0;
      bus.mrr       <= 1'b0;
      bus.cmd_ready <= 1'b0;

      bus.rsp_valid <= rsp_ok;
      if (rsp_ok) bus.rsp_data <= bus.dq_out;
      if (bus.dq_oe && rd_cnt == '0) bus.err <= 1'b1;

      bus.driv_valid  <= head_due;
      bus.dq_in_delay <= head_due ? fifo_data[rd_ptr] : '0;
      if (head_due) rd_ptr <= bump(rd_ptr);
      if (issue_wr) wr_ptr <= bump(wr_ptr);

      case (state)
        ST_RESET: begin
          state     <= ST_MRW0;
          bus.mrw   <= 1'b1;
          bus.addr  <= 8'd0;
          bus.mr_in <= RL8;
        end
        ST_MRW0: begin
          state     <= ST_MRW1;
          bus.mrw   <= 1'b1;
          bus.addr  <= 8'd1;
          bus.mr_in <= WL8;
        end
        ST_MRW1: begin
`ifdef DRAM_CTRL_MR_CHECK_EN
          state    <= ST_MRR0;
          bus.mrr  <= 1'b1;
          bus.addr <= 8'd0;
`else
          state         <= ST_READY;
          bus.init_done <= 1'b1;
          bus.cmd_ready <= can_accept;
`endif
        end
        ST_MRR0: state <= ST_CHK0;
        ST_CHK0: begin
          if (bus.mr_out == RL8) begin
            state    <= ST_MRR1;
            bus.mrr  <= 1'b1;
            bus.addr <= 8'd1;
          end else begin
            state   <= ST_ERROR;
            bus.err <= 1'b1;
          end
        end
        ST_MRR1: state <= ST_CHK1;
        ST_CHK1: begin
          if (bus.mr_out == WL8) begin
            state         <= ST_READY;
            bus.init_done <= 1'b1;
            bus.cmd_ready <= can_accept;
          end else begin
            state   <= ST_ERROR;
            bus.err <= 1'b1;
          end
        end
        ST_READY: begin
          bus.cmd_ready <= can_accept;
          if (accept) begin
            bus.r    <= issue_rd;
            bus.w    <= issue_wr;
            bus.addr <= bus.cmd_addr;
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: directed init/limit/reset cases plus
// random traffic against a due-time based host/DRAM reference model.
module tb_dram_ctrl;
  localparam int RL   = 4;
  localparam int WL   = 3;
  localparam int OUTS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_ctrl_if bus ();

  dram_ctrl #(.RL(RL), .WL(WL), .OUTS(OUTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int due; logic [7:0] data; logic [7:0] addr; } wbeat_t;
  typedef struct { int due; logic [7:0] addr; } rd_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] ref_mem  [256];
  logic [7:0] dram_mem [256];
  wbeat_t     wq[$];
  rd_t        rq[$];
  logic [7:0] exp_rsp[$];
  int         m_rd_out;
  bit         m_err;
  bit         m_cmd_ready;
  bit         auto_rsp;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One model cycle: predict from pre-edge inputs, advance, compare.
  task automatic tick();
    bit er, ew, ed, ev, oe;
    logic [7:0] eaddr, wdata, edata, ersp;
    er    = bus.cmd_valid && m_cmd_ready && !bus.cmd_we;
    ew    = bus.cmd_valid && m_cmd_ready && bus.cmd_we;
    eaddr = bus.cmd_addr;
    wdata = bus.cmd_wdata;
    oe    = bus.dq_oe;
    @(posedge clk); #1;
    cyc++;
    ev = 1'b0; ersp = '0;
    if (oe) begin
      if (m_rd_out > 0) begin
        ev = 1'b1; ersp = exp_rsp.pop_front(); m_rd_out--;
      end else m_err = 1'b1;
    end
    if (er) begin
      m_rd_out++;
      exp_rsp.push_back(ref_mem[eaddr]);
      rq.push_back('{due: cyc + RL, addr: eaddr});
    end
    if (ew) begin
      wq.push_back('{due: cyc + WL, data: wdata, addr: eaddr});
      ref_mem[eaddr] = wdata;
    end
    ed = 1'b0; edata = '0;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      ed = 1'b1; edata = wq[0].data;
      dram_mem[wq[0].addr] = wq[0].data;
      void'(wq.pop_front());
    end
    m_cmd_ready = (m_rd_out < OUTS) && (wq.size() < OUTS);

    chk("cmd_ready", bus.cmd_ready, m_cmd_ready);
    chk("r", bus.r, er);
    chk("w", bus.w, ew);
    chk("mrw", bus.mrw, 1'b0);
    chk("mrr", bus.mrr, 1'b0);
    if (er || ew) chk("addr", bus.addr, eaddr);
    chk("driv_valid", bus.driv_valid, ed);
    chk("dq_in_delay", bus.dq_in_delay, edata);
    chk("rsp_valid", bus.rsp_valid, ev);
    if (ev) chk("rsp_data", bus.rsp_data, ersp);
    chk("err", bus.err, m_err);
    chk("init_done", bus.init_done, 1'b1);

    bus.dq_oe  = 1'b0;
    bus.dq_out = '0;
    if (auto_rsp && rq.size() > 0 && rq[0].due == cyc) begin
      bus.dq_oe  = 1'b1;
      bus.dq_out = dram_mem[rq[0].addr];
      void'(rq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input bit we, input logic [7:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int k = 0; k < 64 && !m_cmd_ready; k++) tick();
    if (!m_cmd_ready) chk("send_wait", bus.cmd_ready, 1'b1);
    tick();
  endtask

  // Manually return the oldest pending DRAM read.
  task automatic pulse_read();
    bus.cmd_valid = 1'b0;
    bus.dq_oe     = 1'b1;
    bus.dq_out    = dram_mem[rq[0].addr];
    void'(rq.pop_front());
    tick();
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.dq_oe     = 1'b0;
    bus.mr_out    = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_strobes", {4'h0, bus.r, bus.w, bus.mrw, bus.mrr}, 8'h00);
    chk("rst_driv_valid", bus.driv_valid, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_addr", bus.addr, 8'h00);
    chk("rst_mr_in", bus.mr_in, 8'h00);
    chk("rst_dq_in_delay", bus.dq_in_delay, 8'h00);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    @(posedge clk); #1;
    wq.delete(); rq.delete(); exp_rsp.delete();
    m_rd_out = 0; m_err = 1'b0; m_cmd_ready = 1'b0; cyc = 0;
    ref_mem = dram_mem;
  endtask

  task automatic init_seq(input logic [7:0] mr0, input bit expect_ok);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("i1_mrw", bus.mrw, 1'b1);
    chk("i1_addr", bus.addr, 8'd0);
    chk("i1_mr_in", bus.mr_in, 8'(RL));
    chk("i1_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    chk("i2_mrw", bus.mrw, 1'b1);
    chk("i2_addr", bus.addr, 8'd1);
    chk("i2_mr_in", bus.mr_in, 8'(WL));
`ifdef DRAM_CTRL_MR_CHECK_EN
    @(posedge clk); #1;
    chk("i3_mrr", bus.mrr, 1'b1);
    chk("i3_mrw", bus.mrw, 1'b0);
    chk("i3_addr", bus.addr, 8'd0);
    bus.mr_out = mr0;
    @(posedge clk); #1;
    chk("i4_mrr", bus.mrr, 1'b0);
    chk("i4_init_done", bus.init_done, 1'b0);
    @(posedge clk); #1;
    if (!expect_ok) begin
      chk("mm_err", bus.err, 1'b1);
      chk("mm_init_done", bus.init_done, 1'b0);
      chk("mm_mrr", bus.mrr, 1'b0);
      return;
    end
    chk("i5_mrr", bus.mrr, 1'b1);
    chk("i5_addr", bus.addr, 8'd1);
    bus.mr_out = 8'(WL);
    @(posedge clk); #1;
    chk("i6_mrr", bus.mrr, 1'b0);
    @(posedge clk); #1;
`else
    @(posedge clk); #1;
    chk("i3_mrr", bus.mrr, 1'b0);
    chk("i3_mrw", bus.mrw, 1'b0);
`endif
    chk("init_done", bus.init_done, 1'b1);
    chk("init_ready", bus.cmd_ready, 1'b1);
    chk("init_err", bus.err, 1'b0);
    m_cmd_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.dq_oe = 1'b0; bus.dq_out = '0; bus.mr_out = '0;
    for (int i = 0; i < 256; i++) dram_mem[i] = 8'($urandom);
    auto_rsp = 1'b1;

    do_reset();
    init_seq(8'(RL), 1'b1);

    // Single write then readback of the same address.
    send(1'b1, 8'h10, 8'hA5);
    idle(WL + 2);
    send(1'b0, 8'h10, 8'h00);
    idle(RL + 3);

    // Fill outstanding reads, hold a blocked command, then release one.
    auto_rsp = 1'b0;
    for (int i = 0; i < OUTS; i++) send(1'b0, 8'(8'h80 + i), 8'h00);
    bus.cmd_addr = 8'hC0;
    repeat (4) tick();
    pulse_read();
    idle(1);
    while (rq.size() > 0) pulse_read();
    auto_rsp = 1'b1;
    idle(2);

    // Back-to-back writes give consecutive beats in order.
    for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(i + 1));
    idle(WL + 2);

    // Random traffic: writes low half, reads high half.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1)
        send(1'b1, 8'($urandom_range(0, 127)), 8'($urandom));
      else
        send(1'b0, 8'($urandom_range(128, 255)), 8'h00);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(10);
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 8'h00);
    idle(RL + 3);

    // Spurious read data sets a sticky error that does not block traffic.
    bus.dq_oe = 1'b1; bus.dq_out = 8'h77;
    tick();
    send(1'b1, 8'h20, 8'h3C);
    idle(WL + 2);
    send(1'b0, 8'h20, 8'h00);
    idle(RL + 3);

    // Reset during a write burst with a read in flight.
    auto_rsp = 1'b0;
    send(1'b0, 8'h90, 8'h00);
    for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h40 + i), 8'(8'hE0 + i));
    do_reset();
    init_seq(8'(RL), 1'b1);
    idle(WL + 2);
    bus.dq_oe = 1'b1; bus.dq_out = 8'h55;
    tick();
    auto_rsp = 1'b1;
    idle(2);

`ifdef DRAM_CTRL_MR_CHECK_EN
    // MR0 readback mismatch locks the controller until reset.
    do_reset();
    init_seq(8'h05, 1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 8'h81;
    repeat (6) begin
      @(posedge clk); #1;
      chk("lock_ready", bus.cmd_ready, 1'b0);
      chk("lock_err", bus.err, 1'b1);
      chk("lock_init_done", bus.init_done, 1'b0);
      chk("lock_r", bus.r, 1'b0);
    end
    do_reset();
    init_seq(8'(RL), 1'b1);
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
